preprocess_ctrl: RTL

Sequencing controller for the `preprocess` 3×3 window line buffer. On a start command it primes the buffer with three image rows, then alternates one-row core passes with one-row refills until every output row of the frame has been produced. It sits between the top-level controller and `preprocess`, and drives `fetch_en`/`core_en` there. It also reports frame progress to the 7-segment driver.

---
 rtl/preprocess_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/preprocess_ctrl.sv
// preprocess_ctrl
// Sequencing controller for the 3x3 window line buffer in `preprocess`.
// A start command primes the buffer with three rows, then the controller
// alternates one-row core passes with one-row refills until the frame's
// output rows are all produced. Frame progress is reported as a row count
// and a per-row pulse for the 7-segment driver.
//
// Optional feature: define PREPROC_CTRL_WDT_EN to add a watchdog that
// forces an ERR state when a PRIME/FETCH/CORE handshake stalls for
// WDT_LIMIT cycles. Without the macro the controller waits indefinitely
// and err_o is tied low.
//
// MAX_IMG_ROWS must be at least 3. MAX_BUF_ROWS is fixed at 3.

module preprocess_ctrl #(
  parameter int MAX_IMG_COLS = 540,
  parameter int MAX_IMG_ROWS = 960,
  parameter int MAX_BUF_ROWS = 3,
  parameter int WDT_LIMIT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        fetch_done_i,
  input  logic        core_done_i,
  output logic        fetch_en_o,
  output logic [10:0] fetch_len_o,
  output logic        core_en_o,
  output logic [9:0]  row_cnt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        n_segment_up_o,
  output logic        err_o
);

  // Fetch lengths and the terminal row count are fixed at elaboration.
  localparam logic [10:0] PRIME_LEN  = 11'(MAX_BUF_ROWS * MAX_IMG_COLS);
  localparam logic [10:0] REFILL_LEN = 11'(MAX_IMG_COLS);
  localparam logic [9:0]  LAST_ROW   = 10'(MAX_IMG_ROWS - 2);

`ifdef PREPROC_CTRL_WDT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_CORE, S_FETCH, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_CORE, S_FETCH, S_DONE
  } state_t;
`endif

  state_t state;

  // Saturating next row count; the frame ends before it could ever wrap.
  logic [9:0] row_cnt_inc;
  assign row_cnt_inc = (row_cnt_o < LAST_ROW) ? row_cnt_o + 10'd1 : row_cnt_o;

  // A handshake that moves the FSM forward out of an active state.
  logic progress;
  assign progress = ((state == S_PRIME || state == S_FETCH) && fetch_done_i) ||
                    ((state == S_CORE) && core_done_i);

  logic active;
  assign active = (state == S_PRIME) || (state == S_FETCH) || (state == S_CORE);

`ifdef PREPROC_CTRL_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_LIMIT - 1);

  logic [15:0] wdt_cnt;
  logic        wdt_expire;

  // Stall has lasted WDT_LIMIT cycles in one active state with no handshake.
  assign wdt_expire = active && !progress && !abort_i && (wdt_cnt == WDT_LAST);

  // Watchdog counter: zero outside active states and on every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= '0;
    end else if (!active || progress || abort_i || wdt_expire) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 16'd1;
    end
  end

  // Error flag: set on watchdog expiry, cleared only by abort or reset.
  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      err_o <= 1'b0;
    end else if (wdt_expire) begin
      err_o <= 1'b1;
    end
  end
`else
  logic wdt_expire;
  assign wdt_expire = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Main FSM with all handshake and status outputs registered alongside state.
  always_ff @(posedge clk) begin
    // NOTE: the reset branch sits inside the clocked block, so reset is
    // only seen on a rising edge; every register has an explicit value.
    if (rst) begin
      state          <= S_IDLE;
      fetch_en_o     <= 1'b0;
      fetch_len_o    <= '0;
      core_en_o      <= 1'b0;
      row_cnt_o      <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      n_segment_up_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge state and the defaults here are overridden
      // cleanly by later assignments in the same edge.
      done_o         <= 1'b0;
      n_segment_up_o <= 1'b0;

      if (abort_i) begin
        // Abort wins over any handshake or start in the same cycle; the
        // row count is held so the reason for the abort can be inspected.
        state      <= S_IDLE;
        fetch_en_o <= 1'b0;
        core_en_o  <= 1'b0;
        busy_o     <= 1'b0;
      end else if (wdt_expire) begin
        state      <= state_t'(3'd5);
        fetch_en_o <= 1'b0;
        core_en_o  <= 1'b0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              state       <= S_PRIME;
              fetch_en_o  <= 1'b1;
              fetch_len_o <= PRIME_LEN;
              row_cnt_o   <= '0;
              busy_o      <= 1'b1;
            end
          end

          S_PRIME, S_FETCH: begin
            if (fetch_done_i) begin
              state      <= S_CORE;
              fetch_en_o <= 1'b0;
              core_en_o  <= 1'b1;
            end
          end

          S_CORE: begin
            if (core_done_i) begin
              core_en_o      <= 1'b0;
              row_cnt_o      <= row_cnt_inc;
              n_segment_up_o <= 1'b1;
              if (row_cnt_inc == LAST_ROW) begin
                state  <= S_DONE;
                done_o <= 1'b1;
                busy_o <= 1'b0;
              end else begin
                state       <= S_FETCH;
                fetch_en_o  <= 1'b1;
                fetch_len_o <= REFILL_LEN;
              end
            end
          end

          S_DONE: begin
            // done_o was raised on entry and drops by the default above.
            state <= S_IDLE;
          end

          default: begin
            // ERR (watchdog build only) holds until abort or reset.
            fetch_en_o <= 1'b0;
            core_en_o  <= 1'b0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
